pixel_sequencer: RTL
====================

PIXEL_SEQUENCER -- requirements
Module: pixel_sequencer

Interface
REQ-001 SHALL have parameter C_ERASE, default 5, erase phase length in cycles when cfg input is 0.
REQ-002 SHALL have parameter C_EXPOSE, default 255, exposure length in cycles when cfg input is 0.
REQ-003 SHALL have parameter C_CONVERT, default 255, conversion length in cycles when cfg input is 0.
REQ-004 SHALL have parameter C_READ, default 5, length in cycles of each read phase when cfg input is 0.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, frame request; sampled only in IDLE.
REQ-008 SHALL have port abort, input, 1, terminate the frame immediately.
REQ-009 SHALL have port cont_mode, input, 1, loop frames until abort; latched at start.
REQ-010 SHALL have port cfg_expose, input, 8, exposure cycles; 0 selects C_EXPOSE; latched at start.
REQ-011 SHALL have port cfg_convert, input, 8, conversion cycles; 0 selects C_CONVERT; latched at start.
REQ-012 SHALL have port rd_ready, input, 1, downstream readout can accept a row-group.
REQ-013 SHALL have ports erase, expose, convert, read0, read1, output, 1 each, registered one-hot pixel-array phase controls.
REQ-014 SHALL have port adc_count, output, 8, ramp counter value during convert.
REQ-015 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-016 SHALL have port done, output, 1, one-cycle pulse at the end of a single-shot frame.
REQ-017 SHALL have port frame_cnt, output, 16, count of completed frames.

Function
REQ-018 SHALL implement states IDLE, ERASE, EXPOSE, CONVERT, READ0, READ1, with phase outputs driven from registers on the same edge as the state register, one-hot per state, and all low in IDLE.
REQ-019 SHALL go from IDLE to ERASE on the edge where start=1, latching cont_mode, cfg_expose and cfg_convert; cfg changes later in the frame SHALL have no effect.
REQ-020 SHALL hold ERASE, EXPOSE and CONVERT for exactly N cycles each: ERASE uses C_ERASE; EXPOSE uses latched cfg_expose, or C_EXPOSE if 0; CONVERT uses latched cfg_convert, or C_CONVERT if 0.
REQ-021 SHALL hold READ0 and READ1 for at least C_READ cycles each; after the down-counter expires, the block SHALL leave the phase only on an edge where rd_ready=1 and SHALL otherwise stay in the phase with the output high.
REQ-022 SHALL advance ERASE->EXPOSE->CONVERT->READ0->READ1 in that order.
REQ-023 SHALL, on READ1 exit, go to ERASE if latched cont_mode=1, else go to IDLE and pulse done for exactly one cycle.
REQ-024 SHALL increment frame_cnt by 1 (modulo 2^16) on every READ1 exit, including on loop frames.
REQ-025 SHALL clear adc_count to 0 on CONVERT entry, increment it by 1 each CONVERT cycle (wrapping 255->0), and hold its last value outside CONVERT.
REQ-026 SHALL, when abort=1 in any non-IDLE state, enter IDLE on the next edge with all phase outputs low, no done pulse and no frame_cnt change; abort SHALL take priority over a simultaneous phase expiry.
REQ-027 SHALL ignore start while busy; start and abort both high in IDLE SHALL leave the block in IDLE.
REQ-028 SHALL use one 8-bit phase down-counter, reloaded on every state entry.

Reset
REQ-029 SHALL, while reset=0, force state IDLE; erase, expose, convert, read0, read1, busy and done to 0; adc_count, frame_cnt and phase counter to 0; and latched config to 0.
REQ-030 SHALL, when reset is asserted mid-frame, abandon the frame with no done pulse and resume from IDLE after release.

Structure
REQ-031 SHALL take the state enumeration and the C_* default constants from a shared package, pixel_pkg, which pixel-array benches also use.
REQ-032 SHALL place the phase down-counter with reload and zero-default selection in one sub-module, phase_timer; the FSM, adc ramp and frame counter SHALL stay at top level.

Verification
REQ-033 The bench SHALL cover: single shot, cfg 0/0, rd_ready=1, start pulse -> phases 5/255/255/5/5 cycles, done pulses once, frame_cnt=1.
REQ-034 The bench SHALL cover: cfg_expose=3, cfg_convert=4 -> EXPOSE 3 cycles, CONVERT 4 cycles, adc_count sequence 1,2,3,4 then held at 4.
REQ-035 The bench SHALL cover: rd_ready=0 for 10 cycles after READ0 expiry -> read0 stays high 15 cycles total, READ1 starts on the cycle after rd_ready rises.
REQ-036 The bench SHALL cover: cont_mode=1, three frames, then abort in EXPOSE -> frame_cnt=3, no done, all outputs low next cycle, busy=0.
REQ-037 The bench SHALL cover: cfg_expose changed mid-frame from 3 to 9 -> current frame still uses 3; next start uses 9.
REQ-038 The bench SHALL cover: reset=0 asserted during CONVERT -> all outputs 0 asynchronously, no done; a start after release runs a full frame with frame_cnt=1.

Source files
------------

// File: rtl/pixel_pkg.sv
// Shared pixel-array definitions: sequencer states and default phase lengths.
package pixel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERASE,
        ST_EXPOSE,
        ST_CONVERT,
        ST_READ0,
        ST_READ1
    } state_e;

    localparam int DEF_ERASE   = 5;
    localparam int DEF_EXPOSE  = 255;
    localparam int DEF_CONVERT = 255;
    localparam int DEF_READ    = 5;

    // A zero configuration value selects the built-in default length.
    function automatic logic [7:0] phase_len(input logic [7:0] cfg, input logic [7:0] dflt);
        return (cfg == 8'd0) ? dflt : cfg;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Single 8-bit phase down-counter; reloaded on every state entry, expires at zero.
module phase_timer
    import pixel_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [7:0] cfg_i,
    input  logic [7:0] dflt_i,
    output logic       expired_o
);

    logic [7:0] cnt_q, cnt_d;

    // Loading N-1 makes the phase last exactly N cycles including the zero cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = phase_len(cfg_i, dflt_i) - 8'd1;
        else if (cnt_q != 8'd0)
            cnt_d = cnt_q - 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 8'd0;
        else        cnt_q <= cnt_d;
    end

    assign expired_o = (cnt_q == 8'd0);

endmodule

// File: rtl/pixel_sequencer.sv
// Pixel-array frame sequencer: erase/expose/convert/read0/read1 with ADC ramp and frame count.
module pixel_sequencer
    import pixel_pkg::*;
#(
    parameter int C_ERASE   = DEF_ERASE,
    parameter int C_EXPOSE  = DEF_EXPOSE,
    parameter int C_CONVERT = DEF_CONVERT,
    parameter int C_READ    = DEF_READ
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        cont_mode,
    input  logic [7:0]  cfg_expose,
    input  logic [7:0]  cfg_convert,
    input  logic        rd_ready,
    output logic        erase,
    output logic        expose,
    output logic        convert,
    output logic        read0,
    output logic        read1,
    output logic [7:0]  adc_count,
    output logic        busy,
    output logic        done,
    output logic [15:0] frame_cnt
);

    state_e      state_q, state_d;
    logic        cont_q, cont_d;
    logic [7:0]  cfg_exp_q, cfg_exp_d;
    logic [7:0]  cfg_conv_q, cfg_conv_d;
    logic [7:0]  adc_q, adc_d;
    logic [15:0] frame_q, frame_d;
    logic        done_q, done_d;
    logic        erase_q, expose_q, convert_q, read0_q, read1_q;
    logic        tm_load, tm_expired;
    logic [7:0]  tm_cfg, tm_dflt;

    always_comb begin
        state_d    = state_q;
        cont_d     = cont_q;
        cfg_exp_d  = cfg_exp_q;
        cfg_conv_d = cfg_conv_q;
        frame_d    = frame_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d    = ST_ERASE;
                    cont_d     = cont_mode;
                    cfg_exp_d  = cfg_expose;
                    cfg_conv_d = cfg_convert;
                end
            end
            default: begin
                // Abort wins over any expiry in the same cycle.
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (tm_expired) begin
                    case (state_q)
                        ST_ERASE:   state_d = ST_EXPOSE;
                        ST_EXPOSE:  state_d = ST_CONVERT;
                        ST_CONVERT: state_d = ST_READ0;
                        ST_READ0:   if (rd_ready) state_d = ST_READ1;
                        ST_READ1: begin
                            if (rd_ready) begin
                                frame_d = frame_q + 16'd1;
                                if (cont_q) begin
                                    state_d = ST_ERASE;
                                end else begin
                                    state_d = ST_IDLE;
                                    done_d  = 1'b1;
                                end
                            end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        adc_d = adc_q;
        if (state_q == ST_CONVERT)
            adc_d = adc_q + 8'd1;
        if (state_d == ST_CONVERT && state_q != ST_CONVERT)
            adc_d = 8'd0;
    end

    // Timer length is selected by the state being entered.
    always_comb begin
        tm_load = (state_d != state_q);
        tm_cfg  = 8'd0;
        tm_dflt = 8'(C_READ);
        case (state_d)
            ST_ERASE:   tm_dflt = 8'(C_ERASE);
            ST_EXPOSE: begin
                tm_cfg  = cfg_exp_q;
                tm_dflt = 8'(C_EXPOSE);
            end
            ST_CONVERT: begin
                tm_cfg  = cfg_conv_q;
                tm_dflt = 8'(C_CONVERT);
            end
            default: ;
        endcase
    end

    phase_timer u_timer (
        .clk       (clk),
        .rst_n     (reset),
        .load_i    (tm_load),
        .cfg_i     (tm_cfg),
        .dflt_i    (tm_dflt),
        .expired_o (tm_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cont_q     <= 1'b0;
            cfg_exp_q  <= 8'd0;
            cfg_conv_q <= 8'd0;
            adc_q      <= 8'd0;
            frame_q    <= 16'd0;
            done_q     <= 1'b0;
            erase_q    <= 1'b0;
            expose_q   <= 1'b0;
            convert_q  <= 1'b0;
            read0_q    <= 1'b0;
            read1_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cont_q     <= cont_d;
            cfg_exp_q  <= cfg_exp_d;
            cfg_conv_q <= cfg_conv_d;
            adc_q      <= adc_d;
            frame_q    <= frame_d;
            done_q     <= done_d;
            erase_q    <= (state_d == ST_ERASE);
            expose_q   <= (state_d == ST_EXPOSE);
            convert_q  <= (state_d == ST_CONVERT);
            read0_q    <= (state_d == ST_READ0);
            read1_q    <= (state_d == ST_READ1);
        end
    end

    assign erase     = erase_q;
    assign expose    = expose_q;
    assign convert   = convert_q;
    assign read0     = read0_q;
    assign read1     = read1_q;
    assign adc_count = adc_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign frame_cnt = frame_q;

endmodule
